// File: rtl/z_core_alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, arbiter state
// encoding and an index-width helper used by the top and the arbiter.
package z_core_alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/z_core_rr_arbiter.sv
// Combinational winner select: searches req starting at ptr, wrapping.
// Ports: req (request vector), ptr (search start), gnt (one-hot), idx.
module z_core_rr_arbiter
    import z_core_alu_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/z_core_alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters; operands and results
// are registered. Ports: clk/rstn, req_* request channels, rsp_* response
// channels, busy, alu_* ALU interface. Z_CORE_ALU_ARB_RR_EN selects
// round-robin arbitration; otherwise fixed priority (index 0 highest).
module z_core_alu_arbiter
    import z_core_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_branch,
    output logic                      busy,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [OP_W-1:0]           alu_inst_type,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_branch
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_t          state;
    arb_state_t          state_nx;
    logic [IW-1:0]       grant;
    logic [IW-1:0]       ptr;
    logic [NUM_REQ-1:0]  win_gnt;
    logic [IW-1:0]       win_idx;
    logic                hs;
    logic                can_accept;
    logic                accept;
    logic [DATA_W-1:0]   sel_in1;
    logic [DATA_W-1:0]   sel_in2;
    logic [OP_W-1:0]     sel_op;

    z_core_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

`ifdef Z_CORE_ALU_ARB_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] = (grant == IW'(i));
            end
        end
    end

    // A pending request may be taken in the same cycle the current
    // response is handed off, giving back-to-back operation.
    assign hs         = |(rsp_valid & rsp_ready);
    assign can_accept = (state == IDLE) || hs;
    assign req_ready  = can_accept ? win_gnt : '0;
    assign accept     = |req_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        sel_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                sel_in1 = req_in1[i*DATA_W +: DATA_W];
                sel_in2 = req_in2[i*DATA_W +: DATA_W];
                sel_op  = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? EXEC : IDLE;
            EXEC:    state_nx = RESP;
            RESP: begin
                if (hs) begin
                    state_nx = accept ? EXEC : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            grant         <= '0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_inst_type <= '0;
            rsp_data      <= '0;
            rsp_branch    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                grant         <= win_idx;
                alu_in1       <= sel_in1;
                alu_in2       <= sel_in2;
                alu_inst_type <= sel_op;
            end
            if (state == EXEC) begin
                rsp_data   <= alu_out;
                rsp_branch <= alu_branch;
            end
        end
    end

endmodule

// File: tb/tb_z_core_alu_arbiter.sv
// Self-checking bench for z_core_alu_arbiter with two requesters.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_z_core_alu_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int OW = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   in1_a [N];
    logic [DW-1:0]   in2_a [N];
    logic [OW-1:0]   op_a  [N];
    logic [N*DW-1:0] req_in1;
    logic [N*DW-1:0] req_in2;
    logic [N*OW-1:0] req_op;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_branch;
    logic            busy;
    logic [DW-1:0]   alu_in1;
    logic [DW-1:0]   alu_in2;
    logic [OW-1:0]   alu_inst_type;
    logic [DW-1:0]   alu_out;
    logic            alu_branch;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign req_in1 = {in1_a[1], in1_a[0]};
    assign req_in2 = {in2_a[1], in2_a[0]};
    assign req_op  = {op_a[1], op_a[0]};

    function automatic logic [DW-1:0] ref_alu(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [OW-1:0] op
    );
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return '0;
        endcase
    endfunction

    assign alu_out    = ref_alu(alu_in1, alu_in2, alu_inst_type);
    assign alu_branch = (alu_in1 == alu_in2);

    z_core_alu_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .OP_W    (OW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_in1       (req_in1),
        .req_in2       (req_in2),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_branch    (rsp_branch),
        .busy          (busy),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_inst_type (alu_inst_type),
        .alu_out       (alu_out),
        .alu_branch    (alu_branch)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] op);
        req_valid[i] = v;
        in1_a[i]     = a;
        in2_a[i]     = b;
        op_a[i]      = op;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int w);
`ifdef Z_CORE_ALU_ARB_RR_EN
        return (w + 1) % N;
`else
        return 0 * w;
`endif
    endfunction

    initial begin
        int ptr_m;
        int outst;
        int cyc;
        int g;
        int w;
        int acc_w;
        int got;
        logic [DW-1:0] exp_d;
        logic          exp_b;
        logic          allowed;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;

        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_alu_in1", 64'(alu_in1), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));

        // Single ADD request
        set_req(0, 1'b1, 32'd2, 32'd3, 4'd0);
        rsp_ready = 2'b11;
        #1;
        chk("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = '0;
        #1;
        chk("single_exec_busy", 64'(busy), 64'(1));
        chk("single_exec_in1", 64'(alu_in1), 64'(2));
        chk("single_exec_rv", 64'(rsp_valid), 64'(0));
        chk("single_exec_rdy", 64'(req_ready), 64'(0));
        tick();
        chk("single_rv", 64'(rsp_valid), 64'(2'b01));
        chk("single_data", 64'(rsp_data), 64'(5));
        chk("single_branch", 64'(rsp_branch), 64'(0));
        tick();
        chk("single_idle", 64'(busy), 64'(0));
        chk("single_idle_rv", 64'(rsp_valid), 64'(0));

        // Simultaneous requests: req0 first, req1 back-to-back
        set_req(0, 1'b1, 32'd5, 32'd3, 4'd1);
        set_req(1, 1'b1, 32'd2, 32'd8, 4'd2);
        #1;
        chk("simul_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("simul_exec_rdy", 64'(req_ready), 64'(0));
        tick();
        chk("simul_rv0", 64'(rsp_valid), 64'(2'b01));
        chk("simul_data0", 64'(rsp_data), 64'(2));
        chk("simul_b2b_rdy", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("simul_b2b_busy", 64'(busy), 64'(1));
        chk("simul_b2b_op", 64'(alu_inst_type), 64'(2));
        tick();
        chk("simul_rv1", 64'(rsp_valid), 64'(2'b10));
        chk("simul_data1", 64'(rsp_data), 64'(512));
        tick();
        chk("simul_idle", 64'(busy), 64'(0));

        // Back-to-back: req1 arrives while req0 response is pending
        set_req(0, 1'b1, 32'd12, 32'd5, 4'd5);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("b2b_data0", 64'(rsp_data), 64'(9));
        set_req(1, 1'b1, 32'd12, 32'd2, 4'd6);
        #1;
        chk("b2b_rdy1", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        #1;
        chk("b2b_no_idle", 64'(busy), 64'(1));
        tick();
        chk("b2b_rv1", 64'(rsp_valid), 64'(2'b10));
        chk("b2b_data1", 64'(rsp_data), 64'(3));
        tick();

        // Backpressure on req0 with req1 waiting
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 32'd10, 32'd20, 4'd3);
        tick();
        req_valid[0] = 1'b0;
        tick();
        set_req(1, 1'b1, 32'd1, 32'd1, 4'd0);
        rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rv", 64'(rsp_valid), 64'(2'b01));
            chk("bp_data", 64'(rsp_data), 64'(1));
            chk("bp_busy", 64'(busy), 64'(1));
            chk("bp_rdy", 64'(req_ready), 64'(0));
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        chk("bp_release_rdy", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk("bp_rv1", 64'(rsp_valid), 64'(2'b10));
        chk("bp_data1", 64'(rsp_data), 64'(2));
        chk("bp_branch1", 64'(rsp_branch), 64'(1));
        tick();

        // Reset during EXEC aborts the operation
        set_req(0, 1'b1, 32'd20, 32'd10, 4'd4);
        tick();
        req_valid[0] = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in1", 64'(alu_in1), 64'(0));
        chk("rst_op", 64'(alu_inst_type), 64'(0));
        chk("rst_rv", 64'(rsp_valid), 64'(0));
        chk("rst_data", 64'(rsp_data), 64'(0));
        #1 rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_rsp", 64'(rsp_valid), 64'(0));
        end

        // Both requesters continuously valid, six operations
        set_req(0, 1'b1, 32'd7, 32'd1, 4'd0);
        set_req(1, 1'b1, 32'd9, 32'd1, 4'd1);
        ptr_m = 0;
        for (int n = 0; n < 6; n++) begin
            got = -1;
            for (int c = 0; c < 8 && got < 0; c++) begin
                #1;
                if (req_ready == 2'b01) got = 0;
                else if (req_ready == 2'b10) got = 1;
                else tick();
            end
            chk("rr_grant", 64'(got), 64'(pick(2'b11, ptr_m)));
            if (got >= 0) ptr_m = next_ptr(got);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic against the reference model
        rstn = 1'b0;
        #1 rstn = 1'b1;
        tick();
        ptr_m = 0;
        outst = 0;
        cyc   = 0;
        g     = 0;
        exp_d = '0;
        exp_b = 1'b0;
        for (int it = 0; it < 600; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 1'b1, 32'($urandom_range(0, 3)),
                                32'($urandom_range(0, 3)),
                                4'($urandom_range(0, 15)));
                    else
                        set_req(i, 1'b1, $urandom, $urandom,
                                4'($urandom_range(0, 15)));
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            exp_rv  = (outst != 0 && cyc >= 2) ? 2'(1 << g) : 2'b00;
            allowed = (outst == 0) || (exp_rv != 0 && rsp_ready[g]);
            w       = pick(req_valid, ptr_m);
            exp_rdy = (allowed && w >= 0) ? 2'(1 << w) : 2'b00;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("rnd_busy", 64'(busy), 64'(outst != 0));
            if (exp_rv != 0) begin
                chk("rnd_data", 64'(rsp_data), 64'(exp_d));
                chk("rnd_branch", 64'(rsp_branch), 64'(exp_b));
                if (rsp_ready[g]) outst = 0;
            end
            acc_w = -1;
            if (allowed && w >= 0) begin
                acc_w = w;
                outst = 1;
                g     = w;
                cyc   = 0;
                exp_d = ref_alu(in1_a[w], in2_a[w], op_a[w]);
                exp_b = (in1_a[w] == in2_a[w]);
                ptr_m = next_ptr(w);
            end
            tick();
            if (outst != 0) cyc++;
            if (acc_w >= 0) req_valid[acc_w] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
